fir_decim: RTL and testbench

- Decimate-by-DECIM FIR filter; the receive-side counterpart of the interpolating fir_tbn datapath.
- Accepts one sample per in_valid strobe and shifts it into an NUM_TAPS-deep delay line.
- On every DECIM-th accepted sample, computes the full dot product with the runtime tap_coeffs and emits one registered, scaled and range-limited output with an out_valid strobe.
- Sits after the interpolator/channel in loopback benches and at the input of rate-reduction chains.

---
 rtl/fir_pkg.sv | 24 ++
 rtl/fir_dot_product.sv | 25 ++
 rtl/fir_decim.sv | 93 +++++++++
 tb/tb_fir_decim.sv | 226 ++++++++++++++++++++++
 4 files changed

// File: rtl/fir_pkg.sv
// Shared FIR definitions: default widths, accumulator sizing and saturation helper.
// Used by fir_decim, fir_dot_product, fir_tbn and the benches.
package fir_pkg;

   localparam int DEF_DATA_WIDTH      = 5;
   localparam int DEF_TAP_COEFF_WIDTH = 5;
   localparam int DEF_NUM_TAPS        = 50;

   // Worst-case sum of taps full-precision products fits without overflow.
   function automatic int acc_width(input int dw, input int cw, input int taps);
      return dw + cw + $clog2(taps);
   endfunction

   function automatic longint sat_to_width(input longint v, input int w);
      longint hi;
      longint lo;
      hi = (longint'(1) <<< (w - 1)) - longint'(1);
      lo = -(longint'(1) <<< (w - 1));
      if (v > hi) return hi;
      if (v < lo) return lo;
      return v;
   endfunction

endpackage

// File: rtl/fir_dot_product.sv
// Combinational multiply-accumulate of NUM_TAPS sample/coefficient pairs.
// Returns the full ACC_WIDTH sum; shared between fir_decim and fir_tbn.
module fir_dot_product
   import fir_pkg::*;
#(
   parameter int DATA_WIDTH      = DEF_DATA_WIDTH,
   parameter int TAP_COEFF_WIDTH = DEF_TAP_COEFF_WIDTH,
   parameter int NUM_TAPS        = DEF_NUM_TAPS,
   parameter int ACC_WIDTH       = acc_width(DATA_WIDTH, TAP_COEFF_WIDTH, NUM_TAPS)
) (
   input  logic signed [DATA_WIDTH-1:0]      samples [NUM_TAPS],
   input  logic signed [TAP_COEFF_WIDTH-1:0] coeffs  [NUM_TAPS],
   output logic signed [ACC_WIDTH-1:0]       sum
);

   localparam int PROD_WIDTH = DATA_WIDTH + TAP_COEFF_WIDTH;

   always_comb begin
      sum = '0;
      for (int k = 0; k < NUM_TAPS; k++) begin
         sum = sum + ACC_WIDTH'(PROD_WIDTH'(samples[k]) * PROD_WIDTH'(coeffs[k]));
      end
   end

endmodule

// File: rtl/fir_decim.sv
// Decimate-by-DECIM FIR with runtime coefficients and registered output strobe.
// Define FIR_DECIM_SAT_EN to saturate the output instead of two's-complement wrap.
module fir_decim
   import fir_pkg::*;
#(
   parameter int DATA_WIDTH      = DEF_DATA_WIDTH,
   parameter int TAP_COEFF_WIDTH = DEF_TAP_COEFF_WIDTH,
   parameter int NUM_TAPS        = DEF_NUM_TAPS,
   parameter int DECIM           = 2,
   parameter int OUT_SHIFT       = 0
) (
   input  logic                              clk,
   input  logic                              rst,
   input  logic                              in_valid,
   input  logic signed [DATA_WIDTH-1:0]      in,
   input  logic signed [TAP_COEFF_WIDTH-1:0] tap_coeffs [NUM_TAPS],
   output logic                              out_valid,
   output logic signed [DATA_WIDTH-1:0]      out
);

   localparam int ACC_WIDTH = acc_width(DATA_WIDTH, TAP_COEFF_WIDTH, NUM_TAPS);
   localparam int PH_WIDTH  = (DECIM > 1) ? $clog2(DECIM) : 1;
   localparam int HIST      = (NUM_TAPS > 1) ? NUM_TAPS - 1 : 1;
   localparam logic [PH_WIDTH-1:0] LAST_PHASE = PH_WIDTH'(DECIM - 1);

   // The oldest delay-line slot never reaches the product sum, so only
   // NUM_TAPS-1 past samples are stored; the incoming sample is tap 0.
   logic signed [DATA_WIDTH-1:0] hist_p0 [HIST];
   logic signed [DATA_WIDTH-1:0] window  [NUM_TAPS];
   logic [PH_WIDTH-1:0]          phase_p0;
   logic                         trigger;
   logic signed [ACC_WIDTH-1:0]  acc;
   logic signed [DATA_WIDTH-1:0] out_p1;
   logic                         vld_p1;

   function automatic logic signed [DATA_WIDTH-1:0] scale_limit(input logic signed [ACC_WIDTH-1:0] a);
      logic signed [ACC_WIDTH-1:0] shifted;
      shifted = a >>> OUT_SHIFT;
`ifdef FIR_DECIM_SAT_EN
      return DATA_WIDTH'(sat_to_width(longint'(shifted), DATA_WIDTH));
`else
      return DATA_WIDTH'(shifted);
`endif
   endfunction

   always_comb begin
      window[0] = in;
      for (int k = 1; k < NUM_TAPS; k++) begin
         window[k] = hist_p0[k-1];
      end
   end

   assign trigger = in_valid && (phase_p0 == LAST_PHASE);

   fir_dot_product #(
      .DATA_WIDTH      (DATA_WIDTH),
      .TAP_COEFF_WIDTH (TAP_COEFF_WIDTH),
      .NUM_TAPS        (NUM_TAPS),
      .ACC_WIDTH       (ACC_WIDTH)
   ) u_dot (
      .samples (window),
      .coeffs  (tap_coeffs),
      .sum     (acc)
   );

   // p0 -> p1: delay line and phase advance; output register loads on trigger
   always_ff @(posedge clk) begin
      if (rst) begin
         for (int k = 0; k < HIST; k++) begin
            hist_p0[k] <= '0;
         end
         phase_p0 <= '0;
         out_p1   <= '0;
         vld_p1   <= 1'b0;
      end else begin
         vld_p1 <= trigger;
         if (in_valid) begin
            hist_p0[0] <= in;
            for (int k = 1; k < HIST; k++) begin
               hist_p0[k] <= hist_p0[k-1];
            end
            phase_p0 <= (phase_p0 == LAST_PHASE) ? '0 : phase_p0 + PH_WIDTH'(1);
         end
         if (trigger) begin
            out_p1 <= scale_limit(acc);
         end
      end
   end

   assign out_valid = vld_p1;
   assign out       = out_p1;

endmodule

// File: tb/tb_fir_decim.sv
// Bench for fir_decim: hand-derived vector table, then random and gapped traffic
// against a sample-history reference model. Honours FIR_DECIM_SAT_EN.
module tb_fir_decim;
   import fir_pkg::*;

   localparam int DW        = DEF_DATA_WIDTH;
   localparam int CW        = DEF_TAP_COEFF_WIDTH;
   localparam int NT        = DEF_NUM_TAPS;
   localparam int DECIM     = 2;
   localparam int OUT_SHIFT = 0;

   logic                 clk = 1'b0;
   logic                 rst;
   logic                 vld_in;
   logic signed [DW-1:0] din;
   logic signed [CW-1:0] coeffs [NT];
   logic                 out_valid;
   logic signed [DW-1:0] dout;

   fir_decim #(
      .DATA_WIDTH      (DW),
      .TAP_COEFF_WIDTH (CW),
      .NUM_TAPS        (NT),
      .DECIM           (DECIM),
      .OUT_SHIFT       (OUT_SHIFT)
   ) dut (
      .clk        (clk),
      .rst        (rst),
      .in_valid   (vld_in),
      .in         (din),
      .tap_coeffs (coeffs),
      .out_valid  (out_valid),
      .out        (dout)
   );

   always #5 clk = ~clk;

   int vectors     = 0;
   int miscompares = 0;

   // Reference model: list of accepted samples (newest first) and a sample count.
   int m_hist [NT];
   int m_count;
   int m_out;
   int m_vld;

   typedef struct {
      bit r;
      bit v;
      int x;
      int ev;
      int ew;   // expected out, wrap build
      int es;   // expected out, saturating build
   } vec_t;

   vec_t tbl [$];

   task automatic check(input string name, input integer act, input integer exp);
      vectors++;
      if (act !== exp) begin
         miscompares++;
         $display("FAIL %s: got %0d, expected %0d", name, act, exp);
      end
   endtask

   function automatic int limit(input int v);
      int m;
      int half;
      int t;
      m    = 1 << DW;
      half = m / 2;
`ifdef FIR_DECIM_SAT_EN
      t = v;
      if (t > half - 1) t = half - 1;
      if (t < -half) t = -half;
`else
      t = ((v % m) + m) % m;
      if (t >= half) t = t - m;
`endif
      return t;
   endfunction

   task automatic model_step(input bit r, input bit v, input int x);
      int acc;
      if (r) begin
         for (int k = 0; k < NT; k++) m_hist[k] = 0;
         m_count = 0;
         m_out   = 0;
         m_vld   = 0;
      end else begin
         m_vld = 0;
         if (v) begin
            for (int k = NT - 1; k > 0; k--) m_hist[k] = m_hist[k-1];
            m_hist[0] = x;
            m_count++;
            if (m_count % DECIM == 0) begin
               acc = 0;
               for (int k = 0; k < NT; k++) acc += int'(coeffs[k]) * m_hist[k];
               m_out = limit(acc >>> OUT_SHIFT);
               m_vld = 1;
            end
         end
      end
   endtask

   task automatic apply(input bit r, input bit v, input int x);
      rst    = r;
      vld_in = v;
      din    = DW'(x);
      @(posedge clk);
      model_step(r, v, int'(din));
      #1;
   endtask

   task automatic set_coeffs_test_plan();
      for (int k = 0; k < NT; k++) coeffs[k] = (k < 4) ? CW'(3) : '0;
   endtask

   task automatic rand_coeffs();
      for (int k = 0; k < NT; k++) coeffs[k] = CW'($urandom);
   endtask

   initial begin
      int exp_out;
      int v;
      int ramp;
      int accepted;
      int strobes;

      rst    = 1'b1;
      vld_in = 1'b0;
      din    = '0;
      set_coeffs_test_plan();

      // reset and impulse
      tbl.push_back('{1, 0,   0, 0,   0,   0});
      tbl.push_back('{1, 1,   5, 0,   0,   0});
      tbl.push_back('{0, 1,   1, 0,   0,   0});
      tbl.push_back('{0, 1,   0, 1,   3,   3});
      tbl.push_back('{0, 1,   0, 0,   3,   3});
      tbl.push_back('{0, 1,   0, 1,   3,   3});
      tbl.push_back('{0, 1,   0, 0,   3,   3});
      tbl.push_back('{0, 1,   0, 1,   0,   0});
      tbl.push_back('{0, 0,   0, 0,   0,   0});
      tbl.push_back('{0, 1,   0, 0,   0,   0});
      tbl.push_back('{0, 1,   0, 1,   0,   0});
      // positive overflow, constant 15
      tbl.push_back('{1, 0,   0, 0,   0,   0});
      tbl.push_back('{0, 1,  15, 0,   0,   0});
      tbl.push_back('{0, 1,  15, 1,  -6,  15});
      tbl.push_back('{0, 1,  15, 0,  -6,  15});
      tbl.push_back('{0, 1,  15, 1, -12,  15});
      tbl.push_back('{0, 1,  15, 0, -12,  15});
      tbl.push_back('{0, 1,  15, 1, -12,  15});
      // negative overflow, constant -16
      tbl.push_back('{1, 0,   0, 0,   0,   0});
      tbl.push_back('{0, 1, -16, 0,   0,   0});
      tbl.push_back('{0, 1, -16, 1,   0, -16});
      tbl.push_back('{0, 1, -16, 0,   0, -16});
      tbl.push_back('{0, 1, -16, 1,   0, -16});
      // reset at phase 1, then impulse: no early strobe, no pre-reset leakage
      tbl.push_back('{1, 0,   0, 0,   0,   0});
      tbl.push_back('{0, 1,   7, 0,   0,   0});
      tbl.push_back('{1, 0,   0, 0,   0,   0});
      tbl.push_back('{0, 1,   1, 0,   0,   0});
      tbl.push_back('{0, 1,   0, 1,   3,   3});
      tbl.push_back('{0, 1,   0, 0,   3,   3});
      tbl.push_back('{0, 1,   0, 1,   3,   3});
      tbl.push_back('{0, 1,   0, 0,   3,   3});
      tbl.push_back('{0, 1,   0, 1,   0,   0});

      foreach (tbl[i]) begin
         apply(tbl[i].r, tbl[i].v, tbl[i].x);
`ifdef FIR_DECIM_SAT_EN
         exp_out = tbl[i].es;
`else
         exp_out = tbl[i].ew;
`endif
         check($sformatf("tbl%0d_valid", i), out_valid, tbl[i].ev);
         check($sformatf("tbl%0d_out", i), dout, exp_out);
      end

      // gapped ramp: one accepted sample every third cycle
      rand_coeffs();
      apply(1, 0, 0);
      ramp     = 0;
      accepted = 0;
      strobes  = 0;
      for (int i = 0; i < 90; i++) begin
         v = (i % 3 == 2) ? 1 : 0;
         apply(0, v[0], ramp);
         if (v != 0) begin
            ramp++;
            accepted++;
         end
         if (out_valid) strobes++;
         check("gap_valid", out_valid, m_vld);
         check("gap_out", dout, m_out);
      end
      check("gap_strobe_count", strobes, accepted / DECIM);

      // largest-magnitude accumulation: every product +256
      for (int k = 0; k < NT; k++) coeffs[k] = CW'(-16);
      apply(1, 0, 0);
      for (int i = 0; i < 60; i++) begin
         apply(0, 1, -16);
         check("max_valid", out_valid, m_vld);
         check("max_out", dout, m_out);
      end

      // random traffic with occasional resets and coefficient changes
      rand_coeffs();
      apply(1, 0, 0);
      for (int i = 0; i < 1500; i++) begin
         if ($urandom_range(0, 39) == 0) rand_coeffs();
         apply($urandom_range(0, 99) == 0, $urandom_range(0, 9) < 7,
               int'($urandom_range(0, 31)) - 16);
         check("rnd_valid", out_valid, m_vld);
         check("rnd_out", dout, m_out);
      end

      $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
      $finish;
   end

endmodule
